// File: rtl/rv_collector_if.sv
// Handshake bundle for rv_collector: WIDTH-bit word stream in,
// COUNT*WIDTH-bit packet stream out.
interface rv_collector_if #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
);
    localparam int CW = $clog2(COUNT) + 1;

    logic                   i_VALID;
    logic                   o_READY;
    logic [WIDTH-1:0]       i_D;
    logic                   i_FLUSH;
    logic [COUNT*WIDTH-1:0] o_Q;
    logic                   o_Q_VALID;
    logic                   i_Q_READY;
    logic [CW-1:0]          o_CNT;

    modport slave (
        input  i_VALID, i_D, i_FLUSH, i_Q_READY,
        output o_READY, o_Q, o_Q_VALID, o_CNT
    );

    modport master (
        output i_VALID, i_D, i_FLUSH, i_Q_READY,
        input  o_READY, o_Q, o_Q_VALID, o_CNT
    );
endinterface

// File: rtl/rv_collector.sv
// Collects COUNT consecutive WIDTH-bit words into one packet and holds it
// on a READY-VALID output until the downstream block accepts it.
module rv_collector #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input logic           i_CLK,
    input logic           i_RST,
    rv_collector_if.slave bus
);
    localparam int            CW       = $clog2(COUNT) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(COUNT);

    typedef enum logic [1:0] {
        S_COLLECT = 2'b01,
        S_FULL    = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [COUNT*WIDTH-1:0] q_q, q_d;

    // NOTE: every always_comb target is given its hold value first, so no branch can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            S_COLLECT: begin
                // Flush wins over a word offered in the same cycle; o_Q is left stale.
                if (bus.i_FLUSH) begin
                    cnt_d = '0;
                end else if (bus.i_VALID) begin
                    for (int k = 0; k < COUNT; k++) begin
                        if (cnt_q == CW'(k)) q_d[k*WIDTH +: WIDTH] = bus.i_D;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FULL;
                        cnt_d   = FULL_CNT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_FULL: begin
                if (bus.i_Q_READY) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the packet register is reset along with the control state because o_Q must read 0 after reset.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    // Handshake outputs decode the state register only; reset masks READY.
    assign bus.o_READY   = (state_q == S_COLLECT) && !i_RST;
    assign bus.o_Q_VALID = (state_q == S_FULL);
    assign bus.o_Q       = q_q;
    assign bus.o_CNT     = cnt_q;
endmodule
